// File: rtl/custom_instruction_arbiter.sv
// Round-robin arbiter sharing one custom-instruction accelerator between CPU_COUNT CPU ports.
// Define ARB_TIMEOUT_EN to build the RSP-state watchdog (TIMEOUT_CYCLES, sticky timeout_err).
module custom_instruction_arbiter #(
    parameter  int CPU_COUNT      = 4,
    parameter  int FUNC_W         = 10,
    parameter  int DATA_W         = 32,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int OWNER_W        = (CPU_COUNT > 1) ? $clog2(CPU_COUNT) : 1
) (
    input  logic                          io_systemClk,
    input  logic                          io_systemResetn,
    input  logic [CPU_COUNT-1:0]          cpu_cmd_valid,
    output logic [CPU_COUNT-1:0]          cpu_cmd_ready,
    input  logic [CPU_COUNT*FUNC_W-1:0]   cpu_function_id,
    input  logic [CPU_COUNT*DATA_W-1:0]   cpu_inputs_0,
    input  logic [CPU_COUNT*DATA_W-1:0]   cpu_inputs_1,
    output logic [CPU_COUNT-1:0]          cpu_rsp_valid,
    input  logic [CPU_COUNT-1:0]          cpu_rsp_ready,
    output logic [CPU_COUNT*DATA_W-1:0]   cpu_outputs_0,
    output logic                          acc_cmd_valid,
    input  logic                          acc_cmd_ready,
    output logic [FUNC_W-1:0]             acc_function_id,
    output logic [DATA_W-1:0]             acc_inputs_0,
    output logic [DATA_W-1:0]             acc_inputs_1,
    input  logic                          acc_rsp_valid,
    output logic                          acc_rsp_ready,
    input  logic [DATA_W-1:0]             acc_outputs_0,
    output logic [OWNER_W-1:0]            owner,
    output logic                          timeout_err
);

    if (CPU_COUNT < 1 || CPU_COUNT > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("custom_instruction_arbiter: CPU_COUNT must be 1..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_RSP,
        ST_DELIVER
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [OWNER_W-1:0]   r_rr_ptr;
    logic [OWNER_W-1:0]   r_owner;
    logic [FUNC_W-1:0]    r_fid;
    logic [DATA_W-1:0]    r_in0;
    logic [DATA_W-1:0]    r_in1;
    logic [DATA_W-1:0]    r_rsp_q;

    logic                 w_grant_found;
    logic [OWNER_W-1:0]   w_grant_idx;
    logic [CPU_COUNT-1:0] w_grant_onehot;
    logic [CPU_COUNT-1:0] w_owner_onehot;
    logic [FUNC_W-1:0]    w_sel_fid;
    logic [DATA_W-1:0]    w_sel_in0;
    logic [DATA_W-1:0]    w_sel_in1;
    logic                 w_deliver_done;
    logic                 w_timeout;

    // Search starts one past the last served CPU, so the CPU just served loses any tie.
    // NOTE: every always_comb output gets a default before any branch; a missed path would infer a latch.
    always_comb begin : grant_search
        logic [OWNER_W-1:0] w_cand;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int k = 1; k <= CPU_COUNT; k++) begin
            w_cand = OWNER_W'((int'(r_rr_ptr) + k) % CPU_COUNT);
            if (!w_grant_found && cpu_cmd_valid[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    assign w_grant_onehot = CPU_COUNT'(1) << w_grant_idx;
    assign w_owner_onehot = CPU_COUNT'(1) << r_owner;
    assign w_sel_fid      = FUNC_W'(cpu_function_id >> (int'(w_grant_idx) * FUNC_W));
    assign w_sel_in0      = DATA_W'(cpu_inputs_0 >> (int'(w_grant_idx) * DATA_W));
    assign w_sel_in1      = DATA_W'(cpu_inputs_1 >> (int'(w_grant_idx) * DATA_W));
    assign w_deliver_done = |(cpu_rsp_ready & w_owner_onehot);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge io_systemClk or negedge io_systemResetn) begin
        if (!io_systemResetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_grant_found)                  w_next_state = ST_CMD;
            ST_CMD:     if (acc_cmd_ready)                  w_next_state = ST_RSP;
            ST_RSP:     if (acc_rsp_valid || w_timeout)     w_next_state = ST_DELIVER;
            ST_DELIVER: if (w_deliver_done)                 w_next_state = ST_IDLE;
            default:                                        w_next_state = ST_IDLE;
        endcase
    end

    // Everything except cpu_cmd_ready decodes registers only, keeping acc_* inputs off cpu_* paths.
    always_comb begin
        cpu_cmd_ready = '0;
        acc_cmd_valid = 1'b0;
        acc_rsp_ready = 1'b0;
        cpu_rsp_valid = '0;
        case (r_state)
            ST_IDLE:    cpu_cmd_ready = w_grant_found ? w_grant_onehot : '0;
            ST_CMD:     acc_cmd_valid = 1'b1;
            ST_RSP:     acc_rsp_ready = 1'b1;
            ST_DELIVER: cpu_rsp_valid = w_owner_onehot;
            default:    ;
        endcase
    end

    always_ff @(posedge io_systemClk or negedge io_systemResetn) begin
        if (!io_systemResetn) begin
            r_rr_ptr <= OWNER_W'(CPU_COUNT - 1);
            r_owner  <= '0;
            r_fid    <= '0;
            r_in0    <= '0;
            r_in1    <= '0;
            r_rsp_q  <= '0;
        end else begin
            if (r_state == ST_IDLE && w_grant_found) begin
                r_owner <= w_grant_idx;
                r_fid   <= w_sel_fid;
                r_in0   <= w_sel_in0;
                r_in1   <= w_sel_in1;
            end
            if (r_state == ST_RSP) begin
                if (acc_rsp_valid) begin
                    r_rsp_q <= acc_outputs_0;
                end else if (w_timeout) begin
                    r_rsp_q <= DATA_W'(32'hDEAD_BEEF);
                end
            end
            if (r_state == ST_DELIVER && w_deliver_done) begin
                r_rr_ptr <= r_owner;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;

    // Counter sits at zero outside RSP, so it is already clear on the first RSP cycle.
    always_ff @(posedge io_systemClk or negedge io_systemResetn) begin
        if (!io_systemResetn) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != ST_RSP) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign w_timeout   = (r_state == ST_RSP) && !acc_rsp_valid &&
                         (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign owner           = r_owner;
    assign acc_function_id = r_fid;
    assign acc_inputs_0    = r_in0;
    assign acc_inputs_1    = r_in1;
    assign cpu_outputs_0   = {CPU_COUNT{r_rsp_q}};

endmodule

// File: tb/tb_custom_instruction_arbiter.sv
// Bench for custom_instruction_arbiter: directed scenarios plus random traffic against a
// transaction-level model of one in-flight command per round-robin grant.
module tb_custom_instruction_arbiter;

    localparam int N  = 4;
    localparam int FW = 10;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef logic [N*FW-1:0] fid_vec_t;
    typedef logic [N*DW-1:0] dat_vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     cpu_cmd_valid;
    logic [N-1:0]     cpu_cmd_ready;
    fid_vec_t         cpu_function_id;
    dat_vec_t         cpu_inputs_0;
    dat_vec_t         cpu_inputs_1;
    logic [N-1:0]     cpu_rsp_valid;
    logic [N-1:0]     cpu_rsp_ready;
    dat_vec_t         cpu_outputs_0;
    logic             acc_cmd_valid;
    logic             acc_cmd_ready;
    logic [FW-1:0]    acc_function_id;
    logic [DW-1:0]    acc_inputs_0;
    logic [DW-1:0]    acc_inputs_1;
    logic             acc_rsp_valid;
    logic             acc_rsp_ready;
    logic [DW-1:0]    acc_outputs_0;
    logic [1:0]       owner;
    logic             timeout_err;

    always #5 clk = ~clk;

    custom_instruction_arbiter #(
        .CPU_COUNT(N), .FUNC_W(FW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .io_systemClk(clk),
        .io_systemResetn(rst_n),
        .cpu_cmd_valid(cpu_cmd_valid),
        .cpu_cmd_ready(cpu_cmd_ready),
        .cpu_function_id(cpu_function_id),
        .cpu_inputs_0(cpu_inputs_0),
        .cpu_inputs_1(cpu_inputs_1),
        .cpu_rsp_valid(cpu_rsp_valid),
        .cpu_rsp_ready(cpu_rsp_ready),
        .cpu_outputs_0(cpu_outputs_0),
        .acc_cmd_valid(acc_cmd_valid),
        .acc_cmd_ready(acc_cmd_ready),
        .acc_function_id(acc_function_id),
        .acc_inputs_0(acc_inputs_0),
        .acc_inputs_1(acc_inputs_1),
        .acc_rsp_valid(acc_rsp_valid),
        .acc_rsp_ready(acc_rsp_ready),
        .acc_outputs_0(acc_outputs_0),
        .owner(owner),
        .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // CPU-side stimulus: a request and its payload are held until granted.
    logic [N-1:0]  req_v;
    logic [FW-1:0] st_fid [N];
    logic [DW-1:0] st_in0 [N];
    logic [DW-1:0] st_in1 [N];

    // Transaction model: one command in flight, tracked by its progress flags.
    int            m_last;
    bit            m_busy, m_cmd_done, m_rsp_done, m_terr;
    int            m_cpu, m_wait;
    logic [FW-1:0] m_fid;
    logic [DW-1:0] m_in0, m_in1, m_res, m_deliver;
    int            granted_cpu;
    int            cyc;

    // Observations of the DUT itself.
    int            d_grants[$];
    int            d_delivered;
    logic [N-1:0]  s_cmd_ready, s_rsp_valid;
    logic          s_acc_cmd_valid;
    dat_vec_t      s_outputs;

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if ((v & onehot(j)) != 0) return onehot(j);
        end
        return '0;
    endfunction

    task automatic new_payload(input int i);
        st_fid[i] = FW'($urandom);
        st_in0[i] = $urandom;
        st_in1[i] = $urandom;
    endtask

    task automatic pack_inputs();
        cpu_cmd_valid   = req_v;
        cpu_function_id = '0;
        cpu_inputs_0    = '0;
        cpu_inputs_1    = '0;
        for (int i = 0; i < N; i++) begin
            cpu_function_id |= fid_vec_t'(st_fid[i]) << (i * FW);
            cpu_inputs_0    |= dat_vec_t'(st_in0[i]) << (i * DW);
            cpu_inputs_1    |= dat_vec_t'(st_in1[i]) << (i * DW);
        end
    endtask

    task automatic model_reset();
        m_last = N - 1;
        m_busy = 0; m_cmd_done = 0; m_rsp_done = 0; m_terr = 0;
        m_cpu = 0; m_wait = 0; m_res = '0; m_deliver = '0;
        granted_cpu = -1;
        d_grants.delete();
        d_delivered = 0;
    endtask

    // Entered at posedge+1 with inputs driven; samples at the falling edge, then moves to the next posedge+1.
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        #4;
        cyc++;
        s_cmd_ready     = cpu_cmd_ready;
        s_rsp_valid     = cpu_rsp_valid;
        s_acc_cmd_valid = acc_cmd_valid;
        s_outputs       = cpu_outputs_0;

        exp_rdy = m_busy ? '0 : rr_pick(cpu_cmd_valid, m_last);
        check("cmd_ready", cpu_cmd_ready, exp_rdy);
        check("acc_cmd_valid", acc_cmd_valid, m_busy && !m_cmd_done);
        if (m_busy && !m_cmd_done) begin
            check("acc_fid", acc_function_id, m_fid);
            check("acc_in0", acc_inputs_0, m_in0);
            check("acc_in1", acc_inputs_1, m_in1);
        end
        check("acc_rsp_ready", acc_rsp_ready, m_busy && m_cmd_done && !m_rsp_done);
        check("cpu_rsp_valid", cpu_rsp_valid, (m_busy && m_rsp_done) ? onehot(m_cpu) : '0);
        if (m_busy && m_rsp_done) check("cpu_outputs", cpu_outputs_0, {N{m_deliver}});
        if (m_busy) check("owner", owner, m_cpu);
        check("timeout_err", timeout_err, m_terr);

        if ((cpu_cmd_ready & cpu_cmd_valid) != 0)
            for (int i = 0; i < N; i++) if (((cpu_cmd_ready & cpu_cmd_valid) & onehot(i)) != 0) d_grants.push_back(i);
        if ((cpu_rsp_valid & cpu_rsp_ready) != 0) d_delivered++;

        granted_cpu = -1;
        if (!m_busy) begin
            if (exp_rdy != 0) begin
                for (int i = 0; i < N; i++) if ((exp_rdy & onehot(i)) != 0) m_cpu = i;
                m_fid = FW'(cpu_function_id >> (m_cpu * FW));
                m_in0 = DW'(cpu_inputs_0 >> (m_cpu * DW));
                m_in1 = DW'(cpu_inputs_1 >> (m_cpu * DW));
                m_res = m_in0 ^ m_in1;
                m_busy = 1; m_cmd_done = 0; m_rsp_done = 0;
                granted_cpu = m_cpu;
            end
        end else if (!m_cmd_done) begin
            if (acc_cmd_ready) begin
                m_cmd_done = 1;
                m_wait = 0;
            end
        end else if (!m_rsp_done) begin
            if (acc_rsp_valid) begin
                m_rsp_done = 1;
                m_deliver  = acc_outputs_0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_wait == TO - 1) begin
                m_rsp_done = 1;
                m_deliver  = 32'hDEAD_BEEF;
                m_terr     = 1;
            end
`endif
            else m_wait++;
        end else if ((cpu_rsp_ready & onehot(m_cpu)) != 0) begin
            m_busy = 0;
            m_last = m_cpu;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_v = '0;
        for (int i = 0; i < N; i++) new_payload(i);
        pack_inputs();
        acc_cmd_ready = 1'b0;
        acc_rsp_valid = 1'b0;
        acc_outputs_0 = '0;
        cpu_rsp_ready = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_owner", owner, 0);
        check("reset_acc_cmd_valid", acc_cmd_valid, 0);
        check("reset_acc_rsp_ready", acc_rsp_ready, 0);
        check("reset_cpu_rsp_valid", cpu_rsp_valid, 0);
        check("reset_acc_fid", acc_function_id, 0);
        check("reset_cpu_outputs", cpu_outputs_0, 0);
        check("reset_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cyc = 0;
        @(posedge clk);
        #1;

        // Single request from CPU 2 with an always-ready echoing accelerator; stray responses in IDLE/CMD.
        apply_reset();
        st_fid[2] = 10'h005; st_in0[2] = 32'h11; st_in1[2] = 32'h22;
        req_v = 4'b0100;
        pack_inputs();
        acc_cmd_ready = 1'b1;
        acc_rsp_valid = 1'b1;
        acc_outputs_0 = 32'hBAD0_BAD0;
        cpu_rsp_ready = '1;
        cycle();
        check("single_grant", s_cmd_ready, 4'b0100);
        req_v = '0; pack_inputs();
        cycle();
        check("single_cmd_latency", s_acc_cmd_valid, 1);
        acc_outputs_0 = st_in0[2] ^ st_in1[2];
        cycle();
        check("single_no_early_rsp", s_rsp_valid, 0);
        cycle();
        check("single_rsp_vec", s_rsp_valid, 4'b0100);
        check("single_rsp_data", s_outputs[2*DW +: DW], 32'h33);

        // Stray responses while idle.
        acc_outputs_0 = 32'hBAD1_BAD1;
        repeat (3) cycle();
        check("stray_no_rsp_valid", s_rsp_valid, 0);

        // Round-robin with all four CPUs requesting continuously.
        apply_reset();
        req_v = '1;
        pack_inputs();
        acc_cmd_ready = 1'b1;
        acc_rsp_valid = 1'b1;
        cpu_rsp_ready = '1;
        repeat (24) begin
            if (granted_cpu >= 0) new_payload(granted_cpu);
            pack_inputs();
            acc_outputs_0 = m_res;
            cycle();
        end
        check("rr_enough_grants", d_grants.size() >= 5, 1);
        if (d_grants.size() >= 5) begin
            check("rr_order_0", d_grants[0], 0);
            check("rr_order_1", d_grants[1], 1);
            check("rr_order_2", d_grants[2], 2);
            check("rr_order_3", d_grants[3], 3);
            check("rr_order_4", d_grants[4], 0);
        end
        for (int k = 1; k < d_grants.size(); k++)
            check("rr_no_repeat", d_grants[k] != d_grants[k-1], 1);

        // Backpressure on every handshake while CPUs 0 and 3 wait.
        apply_reset();
        new_payload(1);
        req_v = 4'b0010;
        pack_inputs();
        cycle();
        new_payload(0); new_payload(3);
        req_v = 4'b1001;
        pack_inputs();
        repeat (5) cycle();
        acc_cmd_ready = 1'b1;
        cycle();
        acc_cmd_ready = 1'b0;
        repeat (7) cycle();
        acc_rsp_valid = 1'b1;
        acc_outputs_0 = m_res;
        cycle();
        acc_rsp_valid = 1'b0;
        acc_outputs_0 = $urandom;
        cpu_rsp_ready = 4'b1101;
        repeat (3) cycle();
        check("bp_no_delivery_yet", d_delivered, 0);
        cpu_rsp_ready = 4'b0010;
        cycle();
        cpu_rsp_ready = '0;
        check("bp_one_delivery", d_delivered, 1);
        check("bp_single_grant", d_grants.size(), 1);
        cycle();
        check("bp_next_grant", (d_grants.size() == 2) ? d_grants[1] : -1, 3);

        // Reset asserted while waiting in RSP.
        apply_reset();
        new_payload(0);
        req_v = 4'b0001;
        pack_inputs();
        acc_cmd_ready = 1'b1;
        cycle();
        req_v = '0; pack_inputs();
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_acc_cmd_valid", acc_cmd_valid, 0);
        check("midrst_acc_rsp_ready", acc_rsp_ready, 0);
        check("midrst_cpu_rsp_valid", cpu_rsp_valid, 0);
        check("midrst_cmd_ready", cpu_cmd_ready, 0);
        check("midrst_acc_in0", acc_inputs_0, 0);
        check("midrst_cpu_outputs", cpu_outputs_0, 0);
        check("midrst_owner", owner, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        new_payload(0); new_payload(3);
        req_v = 4'b1001;
        pack_inputs();
        acc_cmd_ready = 1'b0;
        cycle();
        check("midrst_first_grant", s_cmd_ready, 4'b0001);

`ifdef ARB_TIMEOUT_EN
        // Accelerator never responds.
        begin
            int entry;
            int n;
            apply_reset();
            new_payload(2);
            req_v = 4'b0100;
            pack_inputs();
            acc_cmd_ready = 1'b1;
            cycle();
            req_v = '0; pack_inputs();
            cycle();
            entry = cyc + 1;
            n = 0;
            do begin
                cycle();
                n++;
            end while (s_rsp_valid == 0 && n < 40);
            check("to_latency", cyc - entry, TO);
            check("to_rsp_vec", s_rsp_valid, 4'b0100);
            check("to_data", s_outputs[2*DW +: DW], 32'hDEAD_BEEF);
            check("to_err_set", timeout_err, 1);
            cpu_rsp_ready = '1;
            repeat (3) cycle();
            check("to_err_sticky", timeout_err, 1);
        end
`endif

        // Random traffic.
        apply_reset();
        repeat (3000) begin
            bit in_rsp;
            for (int i = 0; i < N; i++) begin
                logic [N-1:0] bit_i;
                bit_i = onehot(i);
                if (granted_cpu == i) begin
                    new_payload(i);
                    req_v = ($urandom % 2 != 0) ? (req_v | bit_i) : (req_v & ~bit_i);
                end else if ((req_v & bit_i) == 0 && $urandom % 10 < 3) begin
                    new_payload(i);
                    req_v = req_v | bit_i;
                end
            end
            pack_inputs();
            in_rsp        = m_busy && m_cmd_done && !m_rsp_done;
            acc_cmd_ready = ($urandom % 3) != 0;
            acc_rsp_valid = in_rsp ? ($urandom % 10 < 4) : ($urandom % 10 < 2);
            acc_outputs_0 = (in_rsp && acc_rsp_valid) ? m_res : $urandom;
            cpu_rsp_ready = N'($urandom);
            cycle();
        end
        check("rand_progress", d_delivered > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
